// File: rtl/cook_timer.sv
// -----------------------------------------------------------------------------
// cook_timer
//   Kitchen-oven countdown timer. The user sets a cook time with +10 s / +1 min
//   buttons. The timer asks the oven controller to start, and counts down once
//   per second while the oven reports that it is heating. When the time runs
//   out it raises finish.
//
// Parameters
//   TICK_DIV   clk cycles per countdown second (>= 2)
//
// Ports
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   heat       oven is heating; the countdown advances only while 1
//   add_sec10  one-cycle pulse, add 10 s
//   add_min    one-cycle pulse, add 60 s
//   clr        one-cycle pulse, clear time
//   start_btn  one-cycle pulse, start request
//   start      registered one-cycle pulse to the oven controller
//   finish     registered level, 1 exactly while the timer is expired
//   disp       registered BCD time {min_tens, min_units, sec_tens, sec_units}
// -----------------------------------------------------------------------------
module cook_timer #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        heat,
  input  logic        add_sec10,
  input  logic        add_min,
  input  logic        clr,
  input  logic        start_btn,
  output logic        start,
  output logic        finish,
  output logic [15:0] disp
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SET, ST_RUN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          start_q, start_d;
  logic          finish_q;

  logic [15:0]   add_time_s, dec_time_s, dec_add_time_s;
  logic          add_s, tick_s;

  // Subtract one second with BCD borrow. Only used when the time is non-zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Add 60 s (is_min=1) or 10 s (is_min=0) with BCD carry; saturates at 99:59.
  function automatic logic [15:0] bcd_add(input logic [15:0] t, input logic is_min);
    logic [15:0] r;
    logic        carry;
    r = t;
    if (is_min) begin
      carry = 1'b1;
    end else if (t[7:4] == 4'd5) begin
      r[7:4] = 4'd0;
      carry  = 1'b1;
    end else begin
      r[7:4] = t[7:4] + 4'd1;
      carry  = 1'b0;
    end
    if (carry) begin
      if (t[11:8] != 4'd9) begin
        r[11:8] = t[11:8] + 4'd1;
      end else if (t[15:12] != 4'd9) begin
        r[11:8]  = 4'd0;
        r[15:12] = t[15:12] + 4'd1;
      end else begin
        r = 16'h9959;
      end
    end else begin
      r[15:8] = t[15:8];
    end
    return r;
  endfunction

  // add_min outranks add_sec10; clr outranks both inside the state logic.
  assign add_s          = add_min | add_sec10;
  assign tick_s         = heat & (pre_q == PRE_MAX);
  assign add_time_s     = bcd_add(time_q, add_min);
  assign dec_time_s     = bcd_dec(time_q);
  assign dec_add_time_s = bcd_add(dec_time_s, add_min);

  // Next-state, time and prescaler computation.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pre_d   = pre_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          time_d = 16'h0000;
          pre_d  = '0;
        end else if (add_s) begin
          time_d  = add_time_s;
          pre_d   = '0;
          state_d = ST_SET;
        end else begin
          time_d = 16'h0000;
        end
      end
      ST_SET: begin
        if (clr) begin
          time_d  = 16'h0000;
          pre_d   = '0;
          state_d = ST_IDLE;
        end else begin
          if (add_s) begin
            time_d = add_time_s;
            pre_d  = '0;
          end else begin
            time_d = time_q;
          end
          // Heating moves to RUN without decrementing in this cycle; a start
          // request only makes sense while the oven is not yet heating.
          if (heat) begin
            state_d = ST_RUN;
          end else begin
            start_d = start_btn & ~start_q;
          end
        end
      end
      ST_RUN: begin
        if (clr) begin
          // Expire immediately so finish tells the controller to stop heating.
          time_d  = 16'h0000;
          pre_d   = '0;
          state_d = ST_DONE;
        end else if (!heat) begin
          // Pause: prescaler keeps its count for the resume.
          state_d = ST_SET;
          time_d  = add_s ? add_time_s : time_q;
        end else if (tick_s) begin
          pre_d = '0;
          if (add_s) begin
            time_d = dec_add_time_s;
          end else begin
            time_d = dec_time_s;
            if (dec_time_s == 16'h0000) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end else begin
          pre_d  = pre_q + PW'(1);
          time_d = add_s ? add_time_s : time_q;
        end
      end
      ST_DONE: begin
        pre_d = '0;
        if (clr) begin
          time_d  = 16'h0000;
          state_d = ST_IDLE;
        end else if (add_s) begin
          time_d  = add_time_s;
          state_d = ST_SET;
        end else begin
          time_d = 16'h0000;
        end
      end
      default: begin
        time_d  = 16'h0000;
        pre_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, time, prescaler and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      time_q   <= 16'h0000;
      pre_q    <= '0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      pre_q    <= pre_d;
      start_q  <= start_d;
      finish_q <= (state_d == ST_DONE);
    end
  end

  assign disp   = time_q;
  assign start  = start_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        heat;
  logic        add_sec10;
  logic        add_min;
  logic        clr;
  logic        start_btn;
  logic        start;
  logic        finish;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  // Reference model: time kept as plain seconds, phase as a small integer.
  localparam int P_IDLE = 0;
  localparam int P_SET  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;
  int   m_phase;
  int   m_secs;
  int   m_pre;
  logic m_start;
  logic m_finish;

  cook_timer #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .heat     (heat),
    .add_sec10(add_sec10),
    .add_min  (add_min),
    .clr      (clr),
    .start_btn(start_btn),
    .start    (start),
    .finish   (finish),
    .disp     (disp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_disp(input int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int sat(input int v);
    return (v > 5999) ? 5999 : v;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_secs   = 0;
    m_pre    = 0;
    m_start  = 1'b0;
    m_finish = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic am, input logic a10,
                            input logic sb, input logic h);
    int   inc;
    logic st_n;
    inc  = c ? 0 : (am ? 60 : (a10 ? 10 : 0));
    st_n = 1'b0;
    if (m_phase == P_IDLE) begin
      if (c) begin
        m_secs = 0; m_pre = 0;
      end else if (inc > 0) begin
        m_secs = sat(m_secs + inc); m_pre = 0; m_phase = P_SET;
      end
    end else if (m_phase == P_SET) begin
      if (c) begin
        m_secs = 0; m_pre = 0; m_phase = P_IDLE;
      end else begin
        if (inc > 0) begin
          m_secs = sat(m_secs + inc); m_pre = 0;
        end
        if (h) m_phase = P_RUN;
        else if (sb && !m_start) st_n = 1'b1;
      end
    end else if (m_phase == P_RUN) begin
      if (c) begin
        m_secs = 0; m_pre = 0; m_phase = P_DONE;
      end else if (!h) begin
        m_secs = sat(m_secs + inc); m_phase = P_SET;
      end else if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_secs = sat(m_secs - 1 + inc);
        if (m_secs == 0) m_phase = P_DONE;
      end else begin
        m_pre  = m_pre + 1;
        m_secs = sat(m_secs + inc);
      end
    end else begin
      m_pre = 0;
      if (c) begin
        m_secs = 0; m_phase = P_IDLE;
      end else if (inc > 0) begin
        m_secs = inc; m_phase = P_SET;
      end
    end
    m_start  = st_n;
    m_finish = (m_phase == P_DONE);
  endtask

  // Drive one cycle of inputs, advance the model, and land at posedge+1.
  task automatic cyc(input logic c, input logic am, input logic a10,
                     input logic sb, input logic h);
    clr = c; add_min = am; add_sec10 = a10; start_btn = sb; heat = h;
    model_step(c, am, a10, sb, h);
    @(posedge clk);
    #1;
    clr = 1'b0; add_min = 1'b0; add_sec10 = 1'b0; start_btn = 1'b0;
  endtask

  task automatic go_idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    nrst = 1'b0; heat = 1'b0; add_sec10 = 1'b0; add_min = 1'b0;
    clr = 1'b0; start_btn = 1'b0;
    model_reset();
    #12;
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h want 0000", disp); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
    add_min = 1'b1;
    @(posedge clk);
    #1;
    add_min = 1'b0;
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_hold got %h want 0000", disp); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_set_entry();
    go_idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (disp !== 16'h0210) begin errors++; $display("FAIL set_entry_disp got %h want 0210", disp); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL set_entry_finish got %b want 0", finish); end
    checks++; if (disp !== to_disp(m_secs)) begin errors++; $display("FAIL set_entry_model got %h want %h", disp, to_disp(m_secs)); end
  endtask

  task automatic test_countdown();
    go_idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (disp !== 16'h0010) begin errors++; $display("FAIL cd_init got %h want 0010", disp); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL cd_start_pulse got %b want 1", start); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL cd_start_width got %b want 0", start); end
    for (int i = 0; i <= 40; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (disp !== to_disp(m_secs) || finish !== m_finish || start !== m_start) begin
        errors++;
        $display("FAIL cd_step%0d got disp=%h fin=%b st=%b want disp=%h fin=%b st=%b",
                 i, disp, finish, start, to_disp(m_secs), m_finish, m_start);
      end
      if (i == 39) begin
        checks++; if (disp !== 16'h0001 || finish !== 1'b0) begin errors++; $display("FAIL cd_last_sec got %h/%b want 0001/0", disp, finish); end
      end
      if (i == 40) begin
        checks++; if (disp !== 16'h0000 || finish !== 1'b1) begin errors++; $display("FAIL cd_expire got %h/%b want 0000/1", disp, finish); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (finish !== 1'b1 || start !== 1'b0) begin errors++; $display("FAIL cd_done_hold got fin=%b st=%b want 1/0", finish, start); end
    end
  endtask

  task automatic test_pause();
    go_idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL pause_borrow got %h want 0059", disp); end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL pause_hold%0d got %h want 0059", i, disp); end
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL pause_resume_early got %h want 0059", disp); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0058) begin errors++; $display("FAIL pause_resume_tick got %h want 0058", disp); end
  endtask

  task automatic test_saturation();
    go_idle();
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (disp !== 16'h9959) begin errors++; $display("FAIL sat_min got %h want 9959", disp); end
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h9955) begin errors++; $display("FAIL sat_run got %h want 9955", disp); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (disp !== 16'h9959) begin errors++; $display("FAIL sat_sec10 got %h want 9959", disp); end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL prio_clr got %h want 0000", disp); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0000 || start !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL idle_ignore got %h/%b/%b want 0000/0/0", disp, start, finish); end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (disp !== 16'h0100) begin errors++; $display("FAIL prio_min got %h want 0100", disp); end
  endtask

  task automatic test_expiry_add();
    go_idle();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL exp_pre got %h want 0001", disp); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0010 || finish !== 1'b0) begin errors++; $display("FAIL exp_add got %h/%b want 0010/0", disp, finish); end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0009 || finish !== 1'b0) begin errors++; $display("FAIL exp_still_run got %h/%b want 0009/0", disp, finish); end
  endtask

  task automatic test_async_reset();
    go_idle();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (disp !== 16'h0030) begin errors++; $display("FAIL ar_setup got %h want 0030", disp); end
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (disp !== 16'h0000 || start !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL ar_async got %h/%b/%b want 0000/0/0", disp, start, finish); end
    #2;
    nrst = 1'b1;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (start !== 1'b0 || disp !== 16'h0000) begin errors++; $display("FAIL ar_no_start got %b/%h want 0/0000", start, disp); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (start !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL ar_quiet got %b/%b want 0/0", start, finish); end
  endtask

  task automatic test_random();
    logic h;
    logic c, am, a10, sb;
    int   r;
    go_idle();
    h = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      for (int k = 0; k < 60; k++) begin
        r   = $urandom_range(0, 99);
        c   = (r < 2);
        am  = (k < 15) && (r >= 2) && (r < 5);
        a10 = (k < 15) && (r >= 5) && (r < 20);
        sb  = ($urandom_range(0, 9) < 2);
        if ($urandom_range(0, 9) == 0) h = ~h;
        else if ($urandom_range(0, 3) != 0) h = 1'b1;
        cyc(c, am, a10, sb, h);
        checks++;
        if (disp !== to_disp(m_secs) || start !== m_start || finish !== m_finish) begin
          errors++;
          $display("FAIL rand_s%0d_k%0d got disp=%h st=%b fin=%b want disp=%h st=%b fin=%b",
                   seg, k, disp, start, finish, to_disp(m_secs), m_start, m_finish);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_entry();
    test_countdown();
    test_pause();
    test_saturation();
    test_expiry_add();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per countdown second; legal range >= 2.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 heat  input  1  oven heating indication from the oven controller; countdown advances only while 1.
REQ-005 add_sec10  input  1  one-cycle synchronous pulse, add 10 s.
REQ-006 add_min  input  1  one-cycle synchronous pulse, add 60 s.
REQ-007 clr  input  1  one-cycle synchronous pulse, clear time.
REQ-008 start_btn  input  1  one-cycle synchronous pulse, start request.
REQ-009 start  output  1  registered one-cycle pulse to oven controller start input.
REQ-010 finish  output  1  registered level to oven controller finish input; 1 exactly while state DONE.
REQ-011 disp  output  16  remaining time, BCD {min_tens, min_units, sec_tens, sec_units}, registered.

Function
REQ-012 State machine: IDLE (time 00:00, not done), SET (time > 0, not counting), RUN (time > 0, counting), DONE (time 00:00, expired).
REQ-013 Time range 00:00..99:59; seconds tens digit never exceeds 5; digits never exceed 9.
REQ-014 Additions: add_sec10 adds 10 s, add_min adds 60 s, both with BCD carry sec->min; result saturates at 99:59.
REQ-015 Priority on simultaneous pulses: clr > add_min > add_sec10; only the highest-priority pulse takes effect that cycle.
REQ-016 Prescaler: counts 0..TICK_DIV-1 only in RUN; tick = prescaler at TICK_DIV-1 with heat=1; wraps to 0 on tick.
REQ-017 Prescaler holds value when RUN -> SET (pause), resumes on return to RUN; cleared to 0 on clr, on entry to IDLE/DONE, and on any addition made outside RUN.
REQ-018 Tick decrements time by 1 s with BCD borrow (sec_units 0->9, sec_tens 0->5, borrow into minutes).
REQ-019 Tick and addition same cycle: time <= sat(time - 1 s + increment).
REQ-020 IDLE: addition -> SET; start_btn ignored; heat ignored.
REQ-021 SET: heat=1 -> RUN next cycle (no decrement in the transition cycle); start_btn with heat=0 -> start pulse next cycle, state unchanged; clr -> IDLE.
REQ-022 RUN: heat=0 -> SET (pause); tick taking time 00:01 -> 00:00 without same-cycle addition -> DONE; additions accepted, state stays RUN; start_btn ignored.
REQ-023 RUN: clr -> time 00:00, state DONE (finish forces controller to stop heating).
REQ-024 DONE: finish=1 held regardless of heat; addition -> SET with finish=0 next cycle; clr -> IDLE; start_btn ignored.
REQ-025 start never asserted in IDLE, RUN or DONE, never for two consecutive cycles.
REQ-026 finish asserts the cycle after the final tick; start and finish never simultaneously 1.

Reset
REQ-027 nrst=0 immediately forces state IDLE, disp=16'h0000, start=0, finish=0, prescaler=0, independent of clk.
REQ-028 nrst deassertion mid-countdown discards all time; first active edge after release behaves as IDLE.

Verification
REQ-029 TICK_DIV=4; add_min x2, add_sec10 -> disp=16'h0210, state SET, finish=0.
REQ-030 From 00:10 SET: start_btn -> start=1 for exactly 1 cycle next cycle; then heat=1 held -> disp reaches 16'h0000 after 10*4 cycles of RUN, finish=1 the following cycle and held with heat still 1.
REQ-031 Borrow/pause: from 01:00, heat=1 for 6 cycles (1 tick) -> disp=16'h0059; heat=0 for 20 cycles -> disp unchanged; heat=1 -> next tick after remaining 2 prescaler counts -> 16'h0058.
REQ-032 Saturation/priority: at 99:55 add_sec10 -> 16'h9959; clr and add_min same cycle -> 16'h0000, IDLE.
REQ-033 Expiry with add: at 00:01 in RUN, tick coincides with add_sec10 -> disp=16'h0010, state RUN, finish=0.
REQ-034 nrst pulsed low between clk edges during RUN at 00:30 -> disp=0, start=0, finish=0 asynchronously; following start_btn produces no start.
